// File: rtl/dc_dc_buck_timing_pkg.sv
// Shared constants and types for the runtime-programmable buck timing register block.
package dc_dc_buck_timing_pkg;

    // Number of derived switch channels; the formula set defines exactly ten.
    localparam int unsigned NUM_CH  = 10;
    // Number of staging registers.
    localparam int unsigned NUM_REG = 11;

    // Staging register addresses
    localparam logic [3:0] ADDR_DS       = 4'd0;
    localparam logic [3:0] ADDR_DL       = 4'd1;
    localparam logic [3:0] ADDR_DT       = 4'd2;
    localparam logic [3:0] ADDR_OL       = 4'd3;
    localparam logic [3:0] ADDR_DC       = 4'd4;
    localparam logic [3:0] ADDR_DD       = 4'd5;
    localparam logic [3:0] ADDR_OFF_S_A1 = 4'd6;
    localparam logic [3:0] ADDR_OFF_L_A1 = 4'd7;
    localparam logic [3:0] ADDR_OFF_S_B1 = 4'd8;
    localparam logic [3:0] ADDR_OFF_L_B1 = 4'd9;
    localparam logic [3:0] ADDR_D_L_A1   = 4'd10;

    // Channel indices, in bus order
    localparam logic [3:0] CH_S_T  = 4'd0;
    localparam logic [3:0] CH_S_A1 = 4'd1;
    localparam logic [3:0] CH_S_A2 = 4'd2;
    localparam logic [3:0] CH_S_B1 = 4'd3;
    localparam logic [3:0] CH_S_B2 = 4'd4;
    localparam logic [3:0] CH_L_T  = 4'd5;
    localparam logic [3:0] CH_L_A1 = 4'd6;
    localparam logic [3:0] CH_L_A2 = 4'd7;
    localparam logic [3:0] CH_L_B1 = 4'd8;
    localparam logic [3:0] CH_L_B2 = 4'd9;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StCheck,
        StArmed
    } state_e;

endpackage

// File: rtl/dc_dc_buck_chan_calc.sv
// Combinational derivation of one channel's offset/duty from the staged primitives,
// plus the legality check of the whole set. Sums are formed SIZE+3 bits wide so the
// checks see the true values; only the chosen channel result is cut to SIZE bits.
module dc_dc_buck_chan_calc
    import dc_dc_buck_timing_pkg::*;
#(
    parameter int unsigned SIZE = 13
) (
    input  logic [3:0]      idx_i,
    input  logic [SIZE-1:0] ds_i,
    input  logic [SIZE-1:0] dl_i,
    input  logic [SIZE-1:0] dt_i,
    input  logic [SIZE-1:0] ol_i,
    input  logic [SIZE-1:0] dc_i,
    input  logic [SIZE-1:0] dd_i,
    input  logic [SIZE-1:0] off_s_a1_i,
    input  logic [SIZE-1:0] off_l_a1_i,
    input  logic [SIZE-1:0] off_s_b1_i,
    input  logic [SIZE-1:0] off_l_b1_i,
    input  logic [SIZE-1:0] d_l_a1_i,
    output logic [SIZE-1:0] offset_o,
    output logic [SIZE-1:0] duty_o,
    output logic            chk_fail_o
);

    localparam int unsigned W = SIZE + 3;
    // PWM period length, 2**SIZE counts
    localparam logic [W-1:0] MVal = W'(1) << SIZE;

    logic [W-1:0] ds, dl, dt, ol, dc, dd;
    logic [W-1:0] p1, p2, p3, p3_dt, end_ol, p1_ds;

    assign ds = W'(ds_i);
    assign dl = W'(dl_i);
    assign dt = W'(dt_i);
    assign ol = W'(ol_i);
    assign dc = W'(dc_i);
    assign dd = W'(dd_i);

    assign p1     = ol + dc + dt;
    assign p2     = p1 + ds + dt;
    assign p3     = p2 + dd;
    assign p3_dt  = p3 + dt;
    assign end_ol = p3_dt + ol;
    assign p1_ds  = p1 + ds;

    // Last load pulse must end inside the period; load turn-on must not precede zero.
    assign chk_fail_o = (end_ol > MVal) || (dl > p1_ds);

    // Per-channel offset/duty select
    always_comb begin
        offset_o = '0;
        duty_o   = '0;
        unique case (idx_i)
            CH_S_T:  begin offset_o = SIZE'(p1);        duty_o = ds_i;                  end
            CH_S_A1: begin offset_o = off_s_a1_i;       duty_o = SIZE'(ol + dc);        end
            CH_S_A2: begin offset_o = SIZE'(p2);        duty_o = SIZE'(dd + ol);        end
            CH_S_B1: begin offset_o = off_s_b1_i;       duty_o = ol_i;                  end
            CH_S_B2: begin offset_o = SIZE'(p3);        duty_o = SIZE'(MVal - p3);      end
            CH_L_T:  begin offset_o = SIZE'(p2 - dl);   duty_o = dl_i;                  end
            CH_L_A1: begin offset_o = off_l_a1_i;       duty_o = d_l_a1_i;              end
            CH_L_A2: begin offset_o = SIZE'(p1_ds);     duty_o = SIZE'(ol + dd);        end
            CH_L_B1: begin offset_o = off_l_b1_i;       duty_o = SIZE'(p1_ds - dl);     end
            CH_L_B2: begin offset_o = SIZE'(p3_dt);     duty_o = SIZE'(MVal - end_ol);  end
            default: begin offset_o = '0;               duty_o = '0;                    end
        endcase
    end

endmodule

// File: rtl/dc_dc_buck_timing_regs.sv
// Programmable buck timing registers: staging set, multi-cycle channel derivation into a
// shadow set, legality check, and glitch-free commit to the active set on a PWM period start.
module dc_dc_buck_timing_regs #(
    parameter int unsigned SIZE = 13,
    parameter int unsigned N_CH = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [3:0]           wr_addr,
    input  logic [SIZE-1:0]      wr_data,
    output logic                 wr_nack,
    input  logic                 update_req,
    input  logic                 period_start,
    output logic                 busy,
    output logic                 cfg_err,
    output logic                 upd_done,
    output logic                 active_valid,
    output logic [N_CH*SIZE-1:0] offset_bus,
    output logic [N_CH*SIZE-1:0] duty_bus
);

    import dc_dc_buck_timing_pkg::*;

    state_e                state_q, state_d;
    logic [3:0]            idx_q, idx_d;
    logic [SIZE-1:0]       stg_q [NUM_REG];
    logic [SIZE-1:0]       stg_d [NUM_REG];
    logic [SIZE-1:0]       sh_off_q [N_CH];
    logic [SIZE-1:0]       sh_off_d [N_CH];
    logic [SIZE-1:0]       sh_duty_q [N_CH];
    logic [SIZE-1:0]       sh_duty_d [N_CH];
    logic [N_CH*SIZE-1:0]  act_off_q, act_off_d;
    logic [N_CH*SIZE-1:0]  act_duty_q, act_duty_d;
    logic                  wr_nack_q, wr_nack_d;
    logic                  cfg_err_q, cfg_err_d;
    logic                  upd_done_q, upd_done_d;
    logic                  active_valid_q, active_valid_d;

    logic                  wr_ok;
    logic [SIZE-1:0]       calc_off, calc_duty;
    logic                  calc_fail;

    dc_dc_buck_chan_calc #(
        .SIZE (SIZE)
    ) u_chan_calc (
        .idx_i      (idx_q),
        .ds_i       (stg_q[ADDR_DS]),
        .dl_i       (stg_q[ADDR_DL]),
        .dt_i       (stg_q[ADDR_DT]),
        .ol_i       (stg_q[ADDR_OL]),
        .dc_i       (stg_q[ADDR_DC]),
        .dd_i       (stg_q[ADDR_DD]),
        .off_s_a1_i (stg_q[ADDR_OFF_S_A1]),
        .off_l_a1_i (stg_q[ADDR_OFF_L_A1]),
        .off_s_b1_i (stg_q[ADDR_OFF_S_B1]),
        .off_l_b1_i (stg_q[ADDR_OFF_L_B1]),
        .d_l_a1_i   (stg_q[ADDR_D_L_A1]),
        .offset_o   (calc_off),
        .duty_o     (calc_duty),
        .chk_fail_o (calc_fail)
    );

    assign wr_ok = wr_en && (state_q == StIdle) && (wr_addr <= ADDR_D_L_A1);

    // Next-state logic: staging writes, FSM sequencing, shadow fill and commit
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        stg_d          = stg_q;
        sh_off_d       = sh_off_q;
        sh_duty_d      = sh_duty_q;
        act_off_d      = act_off_q;
        act_duty_d     = act_duty_q;
        cfg_err_d      = cfg_err_q;
        active_valid_d = active_valid_q;
        upd_done_d     = 1'b0;
        wr_nack_d      = wr_en && !wr_ok;

        if (wr_ok) begin
            stg_d[wr_addr] = wr_data;
        end

        unique case (state_q)
            StIdle: begin
                if (update_req) begin
                    state_d   = StCalc;
                    idx_d     = '0;
                    cfg_err_d = 1'b0;
                end
            end
            StCalc: begin
                sh_off_d[idx_q]  = calc_off;
                sh_duty_d[idx_q] = calc_duty;
                if (idx_q == 4'(N_CH - 1)) begin
                    state_d = StCheck;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            StCheck: begin
                if (calc_fail) begin
                    cfg_err_d = 1'b1;
                    state_d   = StIdle;
                    for (int k = 0; k < N_CH; k++) begin
                        sh_off_d[k]  = '0;
                        sh_duty_d[k] = '0;
                    end
                end else begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                // Swap only at a period boundary so no PWM period sees a mixed set.
                if (period_start) begin
                    for (int k = 0; k < N_CH; k++) begin
                        act_off_d[k*SIZE +: SIZE]  = sh_off_q[k];
                        act_duty_d[k*SIZE +: SIZE] = sh_duty_q[k];
                    end
                    upd_done_d     = 1'b1;
                    active_valid_d = 1'b1;
                    state_d        = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset clearing every set and output
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            idx_q          <= '0;
            act_off_q      <= '0;
            act_duty_q     <= '0;
            wr_nack_q      <= 1'b0;
            cfg_err_q      <= 1'b0;
            upd_done_q     <= 1'b0;
            active_valid_q <= 1'b0;
            for (int r = 0; r < NUM_REG; r++) begin
                stg_q[r] <= '0;
            end
            for (int k = 0; k < N_CH; k++) begin
                sh_off_q[k]  <= '0;
                sh_duty_q[k] <= '0;
            end
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            stg_q          <= stg_d;
            sh_off_q       <= sh_off_d;
            sh_duty_q      <= sh_duty_d;
            act_off_q      <= act_off_d;
            act_duty_q     <= act_duty_d;
            wr_nack_q      <= wr_nack_d;
            cfg_err_q      <= cfg_err_d;
            upd_done_q     <= upd_done_d;
            active_valid_q <= active_valid_d;
        end
    end

    assign busy         = (state_q != StIdle);
    assign wr_nack      = wr_nack_q;
    assign cfg_err      = cfg_err_q;
    assign upd_done     = upd_done_q;
    assign active_valid = active_valid_q;
    assign offset_bus   = act_off_q;
    assign duty_bus     = act_duty_q;

endmodule

// File: tb/tb_dc_dc_buck_timing_regs.sv
// Scoreboard bench for dc_dc_buck_timing_regs: stimulus queues expected commits and nacks,
// a negedge monitor pops and compares them whenever the DUT presents upd_done or wr_nack.
module tb_dc_dc_buck_timing_regs;

    localparam int SIZE = 13;
    localparam int N_CH = 10;
    localparam int BW   = N_CH * SIZE;

    logic            clk = 1'b0;
    logic            reset;
    logic            wr_en;
    logic [3:0]      wr_addr;
    logic [SIZE-1:0] wr_data;
    logic            wr_nack;
    logic            update_req;
    logic            period_start;
    logic            busy;
    logic            cfg_err;
    logic            upd_done;
    logic            active_valid;
    logic [BW-1:0]   offset_bus;
    logic [BW-1:0]   duty_bus;

    dc_dc_buck_timing_regs #(
        .SIZE (SIZE),
        .N_CH (N_CH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_nack      (wr_nack),
        .update_req   (update_req),
        .period_start (period_start),
        .busy         (busy),
        .cfg_err      (cfg_err),
        .upd_done     (upd_done),
        .active_valid (active_valid),
        .offset_bus   (offset_bus),
        .duty_bus     (duty_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] off;
        logic [BW-1:0] duty;
    } commit_t;

    commit_t exp_q[$];
    int      nack_q[$];
    int      errors = 0;
    int      checks = 0;

    // Hand-computed channel tables, order s_t s_a1 s_a2 s_b1 s_b2 l_t l_a1 l_a2 l_b1 l_b2
    int nom_off[10]  = '{160, 0, 3200, 0, 3300, 400, 0, 3160, 0, 3340};
    int nom_duty[10] = '{3000, 120, 120, 20, 4892, 2800, 160, 120, 360, 4832};
    // DS=7832: last load pulse ends exactly at 8192
    int bnd_off[10]  = '{160, 0, 8032, 0, 8132, 5232, 0, 7992, 0, 8172};
    int bnd_duty[10] = '{7832, 120, 120, 20, 60, 2800, 160, 120, 5192, 0};
    // DL=3160 (equal to P1+DS), offsets 11/22/33/44, D_L_A1=500
    int set2_off[10]  = '{160, 11, 3200, 33, 3300, 40, 22, 3160, 44, 3340};
    int set2_duty[10] = '{3000, 120, 120, 20, 4892, 3160, 500, 120, 0, 4832};
    // Same as set2 with DD=200
    int set3_off[10]  = '{160, 11, 3200, 33, 3400, 40, 22, 3160, 44, 3440};
    int set3_duty[10] = '{3000, 120, 220, 20, 4792, 3160, 500, 220, 0, 4732};

    function automatic logic [BW-1:0] pack(input int v[10]);
        logic [BW-1:0] r;
        r = '0;
        for (int k = 0; k < N_CH; k++) begin
            r[k*SIZE +: SIZE] = SIZE'(v[k]);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input int data, input bit expect_nack);
        if (expect_nack) nack_q.push_back(addr);
        wr_en   = 1'b1;
        wr_addr = 4'(addr);
        wr_data = SIZE'(data);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_upd();
        update_req = 1'b1;
        tick();
        update_req = 1'b0;
    endtask

    task automatic pulse_ps();
        period_start = 1'b1;
        tick();
        period_start = 1'b0;
    endtask

    task automatic expect_commit(input int o[10], input int d[10]);
        commit_t c;
        c.off  = pack(o);
        c.duty = pack(d);
        exp_q.push_back(c);
    endtask

    // Monitor: every upd_done / wr_nack pulse must match a queued expectation
    always @(negedge clk) begin
        commit_t c;
        int      a;
        if (!reset && upd_done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_commit: upd_done=1, required 0");
            end else begin
                c = exp_q.pop_front();
                chk("commit_offset_bus", offset_bus, c.off);
                chk("commit_duty_bus", duty_bus, c.duty);
                chk("commit_active_valid", BW'(active_valid), BW'(1));
            end
        end
        if (!reset && wr_nack) begin
            checks++;
            if (nack_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_wr_nack: wr_nack=1, required 0");
            end else begin
                a = nack_q.pop_front();
            end
        end
    end

    initial begin
        reset        = 1'b1;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        update_req   = 1'b0;
        period_start = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        chk("rst_offset_bus", offset_bus, '0);
        chk("rst_duty_bus", duty_bus, '0);
        chk("rst_active_valid", BW'(active_valid), '0);
        chk("rst_busy", BW'(busy), '0);
        chk("rst_cfg_err", BW'(cfg_err), '0);

        // Nominal staging set, plus an out-of-range address
        wr(0, 3000, 0); wr(1, 2800, 0); wr(2, 40, 0); wr(3, 20, 0);
        wr(4, 100, 0);  wr(5, 100, 0);  wr(6, 0, 0);  wr(7, 0, 0);
        wr(8, 0, 0);    wr(9, 0, 0);    wr(10, 160, 0);
        wr(11, 999, 1);

        // Nominal update with busy-phase disturbances
        pulse_upd();
        chk("calc_busy", BW'(busy), BW'(1));
        wr(0, 5, 1);
        pulse_upd();
        pulse_ps();
        repeat (9) tick();
        chk("armed_busy", BW'(busy), BW'(1));
        chk("armed_not_valid", BW'(active_valid), '0);
        expect_commit(nom_off, nom_duty);
        pulse_ps();
        tick();
        chk("post_commit_busy", BW'(busy), '0);
        chk("post_commit_cfg_err", BW'(cfg_err), '0);

        // Overflow reject: DS=8000
        wr(0, 8000, 0);
        pulse_upd();
        repeat (12) tick();
        chk("ovf_cfg_err", BW'(cfg_err), BW'(1));
        chk("ovf_busy", BW'(busy), '0);
        pulse_ps();
        repeat (2) tick();
        chk("ovf_keeps_offset", offset_bus, pack(nom_off));
        chk("ovf_keeps_duty", duty_bus, pack(nom_duty));

        // Boundary accept: end of last load pulse exactly at period end
        wr(0, 7832, 0);
        pulse_upd();
        chk("bnd_cfg_err_cleared", BW'(cfg_err), '0);
        repeat (12) tick();
        chk("bnd_cfg_err", BW'(cfg_err), '0);
        expect_commit(bnd_off, bnd_duty);
        pulse_ps();
        tick();

        // Negative reject: DL=3200 > P1+DS=3160
        wr(0, 3000, 0);
        wr(1, 3200, 0);
        pulse_upd();
        repeat (12) tick();
        chk("neg_cfg_err", BW'(cfg_err), BW'(1));
        pulse_ps();
        repeat (2) tick();
        chk("neg_keeps_offset", offset_bus, pack(bnd_off));

        // DL at its limit plus distinct offsets; next update clears cfg_err
        wr(1, 3160, 0); wr(6, 11, 0); wr(7, 22, 0); wr(8, 33, 0);
        wr(9, 44, 0);   wr(10, 500, 0);
        pulse_upd();
        chk("set2_cfg_err_cleared", BW'(cfg_err), '0);
        repeat (12) tick();
        chk("set2_armed_busy", BW'(busy), BW'(1));
        expect_commit(set2_off, set2_duty);
        pulse_ps();
        tick();

        // DD change
        wr(5, 200, 0);
        pulse_upd();
        repeat (12) tick();
        expect_commit(set3_off, set3_duty);
        pulse_ps();
        tick();

        // Reset while armed
        pulse_upd();
        repeat (12) tick();
        chk("rearm_busy", BW'(busy), BW'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("armrst_offset_bus", offset_bus, '0);
        chk("armrst_duty_bus", duty_bus, '0);
        chk("armrst_active_valid", BW'(active_valid), '0);
        chk("armrst_busy", BW'(busy), '0);
        pulse_ps();
        repeat (3) tick();
        chk("armrst_no_commit_offset", offset_bus, '0);
        chk("armrst_no_commit_valid", BW'(active_valid), '0);

        // Every queued expectation must have been consumed
        chk("pending_commits", BW'(exp_q.size()), '0);
        chk("pending_nacks", BW'(nack_q.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
